// File: rtl/iob_arb_rr2_pkg.sv
// Shared definitions for the two-manager round-robin IOb arbiter:
// FSM state encodings and the state type used by the top level.
package iob_arb_rr2_pkg;

  // Raw state encodings, kept as plain localparams so other blocks can match them
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT  = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;

  // Arbiter FSM state; the fourth code is unreachable and recovers to idle
  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_GRANT  = GRANT,
    ST_WAIT_R = WAIT_R,
    ST_UNUSED = 2'd3
  } state_t;

endpackage

// File: rtl/iob_arb_rr2_sel.sv
// Round-robin winner selection for two requesters. A lone requester always
// wins; on contention the requester whose index equals the pointer wins.
module iob_arb_rr2_sel (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       winner_o
);

  // Pick the winning manager index from the request vector and the pointer
  always_comb begin
    winner_o = 1'b0;
    case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ptr_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/iob_arb_rr2.sv
// Shares one IOb subordinate between two IOb managers, one transaction in
// flight at a time. Request path is a combinational mirror of the granted
// manager while in GRANT; read data is routed back only in WAIT_R. Nothing
// on the request side depends on s_iob_ready_i, so there is no ready->valid
// combinational path.
module iob_arb_rr2
  import iob_arb_rr2_pkg::*;
#(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,

  input  logic                m0_iob_valid_i,
  input  logic [ADDR_W-1:0]   m0_iob_addr_i,
  input  logic [DATA_W-1:0]   m0_iob_wdata_i,
  input  logic [DATA_W/8-1:0] m0_iob_wstrb_i,
  output logic                m0_iob_ready_o,
  output logic [DATA_W-1:0]   m0_iob_rdata_o,
  output logic                m0_iob_rvalid_o,

  input  logic                m1_iob_valid_i,
  input  logic [ADDR_W-1:0]   m1_iob_addr_i,
  input  logic [DATA_W-1:0]   m1_iob_wdata_i,
  input  logic [DATA_W/8-1:0] m1_iob_wstrb_i,
  output logic                m1_iob_ready_o,
  output logic [DATA_W-1:0]   m1_iob_rdata_o,
  output logic                m1_iob_rvalid_o,

  output logic                s_iob_valid_o,
  output logic [ADDR_W-1:0]   s_iob_addr_o,
  output logic [DATA_W-1:0]   s_iob_wdata_o,
  output logic [DATA_W/8-1:0] s_iob_wstrb_o,
  input  logic                s_iob_ready_i,
  input  logic [DATA_W-1:0]   s_iob_rdata_i,
  input  logic                s_iob_rvalid_i
);

  localparam int WSTRB_W = DATA_W / 8;

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 ptr_q, ptr_d;

  logic [1:0]           req_s;
  logic                 winner_s;
  logic                 gnt_valid_s;
  logic [ADDR_W-1:0]    gnt_addr_s;
  logic [DATA_W-1:0]    gnt_wdata_s;
  logic [WSTRB_W-1:0]   gnt_wstrb_s;

  assign req_s = {m1_iob_valid_i, m0_iob_valid_i};

  iob_arb_rr2_sel u_sel (
    .req_i    (req_s),
    .ptr_i    (ptr_q),
    .winner_o (winner_s)
  );

  // Select the request fields of the currently granted manager
  always_comb begin
    if (grant_q) begin
      gnt_valid_s = m1_iob_valid_i;
      gnt_addr_s  = m1_iob_addr_i;
      gnt_wdata_s = m1_iob_wdata_i;
      gnt_wstrb_s = m1_iob_wstrb_i;
    end else begin
      gnt_valid_s = m0_iob_valid_i;
      gnt_addr_s  = m0_iob_addr_i;
      gnt_wdata_s = m0_iob_wdata_i;
      gnt_wstrb_s = m0_iob_wstrb_i;
    end
  end

  // Next-state logic: arbitrate in IDLE, complete or withdraw in GRANT,
  // wait for read data in WAIT_R; the pointer only moves on completion
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_s) begin
          grant_d = winner_s;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!gnt_valid_s) begin
          state_d = ST_IDLE;
        end else if (s_iob_ready_i) begin
          if (|gnt_wstrb_s) begin
            state_d = ST_IDLE;
            ptr_d   = ~grant_q;
          end else begin
            state_d = ST_WAIT_R;
          end
        end else begin
          state_d = ST_GRANT;
        end
      end
      ST_WAIT_R: begin
        if (s_iob_rvalid_i) begin
          state_d = ST_IDLE;
          ptr_d   = ~grant_q;
        end else begin
          state_d = ST_WAIT_R;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and pointer registers; everything holds while cke_i is low
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end else begin
      state_q <= state_q;
      grant_q <= grant_q;
      ptr_q   <= ptr_q;
    end
  end

  // Output routing: request mirror and ready in GRANT, read return in WAIT_R
  always_comb begin
    s_iob_valid_o   = 1'b0;
    s_iob_addr_o    = '0;
    s_iob_wdata_o   = '0;
    s_iob_wstrb_o   = '0;
    m0_iob_ready_o  = 1'b0;
    m1_iob_ready_o  = 1'b0;
    m0_iob_rdata_o  = '0;
    m1_iob_rdata_o  = '0;
    m0_iob_rvalid_o = 1'b0;
    m1_iob_rvalid_o = 1'b0;
    case (state_q)
      ST_GRANT: begin
        s_iob_valid_o = gnt_valid_s;
        s_iob_addr_o  = gnt_addr_s;
        s_iob_wdata_o = gnt_wdata_s;
        s_iob_wstrb_o = gnt_wstrb_s;
        if (grant_q) begin
          m1_iob_ready_o = s_iob_ready_i;
        end else begin
          m0_iob_ready_o = s_iob_ready_i;
        end
      end
      ST_WAIT_R: begin
        if (grant_q) begin
          m1_iob_rvalid_o = s_iob_rvalid_i;
          m1_iob_rdata_o  = s_iob_rdata_i;
        end else begin
          m0_iob_rvalid_o = s_iob_rvalid_i;
          m0_iob_rdata_o  = s_iob_rdata_i;
        end
      end
      default: begin
        s_iob_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_iob_arb_rr2.sv
// Scoreboard bench for iob_arb_rr2: directed transactions are queued to a
// manager driver, expected accepts and read data are queued separately and
// popped by a monitor whenever the DUT shows an accept or an rvalid.
module tb_iob_arb_rr2;
  import iob_arb_rr2_pkg::*;

  localparam int AW = 21;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n, cke;
  logic          mvalid [2];
  logic [AW-1:0] maddr  [2];
  logic [DW-1:0] mwdata [2];
  logic [SW-1:0] mwstrb [2];
  logic          mready [2];
  logic [DW-1:0] mrdata [2];
  logic          mrvalid[2];
  logic          s_valid, s_ready, s_rvalid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;

  iob_arb_rr2 dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .m0_iob_valid_i(mvalid[0]), .m0_iob_addr_i(maddr[0]), .m0_iob_wdata_i(mwdata[0]),
    .m0_iob_wstrb_i(mwstrb[0]), .m0_iob_ready_o(mready[0]), .m0_iob_rdata_o(mrdata[0]),
    .m0_iob_rvalid_o(mrvalid[0]),
    .m1_iob_valid_i(mvalid[1]), .m1_iob_addr_i(maddr[1]), .m1_iob_wdata_i(mwdata[1]),
    .m1_iob_wstrb_i(mwstrb[1]), .m1_iob_ready_o(mready[1]), .m1_iob_rdata_o(mrdata[1]),
    .m1_iob_rvalid_o(mrvalid[1]),
    .s_iob_valid_o(s_valid), .s_iob_addr_o(s_addr), .s_iob_wdata_o(s_wdata),
    .s_iob_wstrb_o(s_wstrb), .s_iob_ready_i(s_ready), .s_iob_rdata_i(s_rdata),
    .s_iob_rvalid_i(s_rvalid)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [SW-1:0] wstrb; } txn_t;
  typedef struct packed { logic mgr; txn_t t; } acc_t;

  txn_t          mq[2][$];
  acc_t          exp_acc[$];
  logic [DW-1:0] exp_rd[2][$];
  bit            busy[2];
  int            n_vec = 0;
  int            n_err = 0;
  bit            sub_stall = 1'b0;
  int            sub_lat = 2;
  int            rv_cnt = 0;

  // Subordinate read data: 0xCAFE0000 + addr/16
  logic [DW-1:0] r0_tab[4] = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004};
  logic [DW-1:0] r1_tab[4] = '{32'hCAFE0010, 32'hCAFE0011, 32'hCAFE0012, 32'hCAFE0013};
  logic [AW-1:0] a0_tab[4] = '{21'h010, 21'h020, 21'h030, 21'h040};
  logic [AW-1:0] a1_tab[4] = '{21'h100, 21'h110, 21'h120, 21'h130};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    txn_t t;
    t.addr = a; t.wdata = d; t.wstrb = s;
    mq[k].push_back(t);
  endtask

  task automatic exp_a(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    acc_t e;
    e.mgr = (k == 1); e.t.addr = a; e.t.wdata = d; e.t.wstrb = s;
    exp_acc.push_back(e);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_acc.size() + exp_rd[0].size() + exp_rd[1].size() + mq[0].size() + mq[1].size()) != 0
           || busy[0] || busy[1]) begin
      @(posedge clk);
      t++;
      if (t > 400) begin
        n_vec++; n_err++;
        $display("FAIL wait_idle: timeout, %0d accepts still pending, expected 0", exp_acc.size());
        exp_acc.delete(); exp_rd[0].delete(); exp_rd[1].delete(); mq[0].delete(); mq[1].delete();
        break;
      end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_state(input logic [1:0] st, input string nm);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (dut.state_q != st && t < 60);
    if (dut.state_q != st) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout, state got %0d, expected %0d", nm, dut.state_q, st);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_m0_ready"}, mready[0], 0);
    chk({nm, "_m1_ready"}, mready[1], 0);
    chk({nm, "_m0_rvalid"}, mrvalid[0], 0);
    chk({nm, "_m1_rvalid"}, mrvalid[1], 0);
    chk({nm, "_s_valid"}, s_valid, 0);
    chk({nm, "_state"}, dut.state_q, 0);
    chk({nm, "_grant"}, dut.grant_q, 0);
    chk({nm, "_ptr"}, dut.ptr_q, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk_quiet("reset");
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  // Manager driver: holds each request until accepted, waits for read data
  initial begin : drv
    txn_t cur[2];
    bit   waitr[2];
    bit   acc[2];
    bit   rv[2];
    for (int k = 0; k < 2; k++) begin
      mvalid[k] = 1'b0; maddr[k] = '0; mwdata[k] = '0; mwstrb[k] = '0;
      busy[k] = 1'b0; waitr[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        acc[k] = mvalid[k] & mready[k] & cke;
        rv[k]  = mrvalid[k];
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!arst_n) begin
          busy[k] = 1'b0; waitr[k] = 1'b0; mvalid[k] = 1'b0;
        end else if (busy[k] && !waitr[k] && acc[k]) begin
          mvalid[k] = 1'b0;
          if (cur[k].wstrb == 4'h0) waitr[k] = 1'b1;
          else busy[k] = 1'b0;
        end else if (busy[k] && waitr[k] && rv[k]) begin
          busy[k] = 1'b0; waitr[k] = 1'b0;
        end
        if (arst_n && !busy[k] && mq[k].size() > 0) begin
          cur[k] = mq[k].pop_front();
          busy[k] = 1'b1;
          maddr[k] = cur[k].addr; mwdata[k] = cur[k].wdata; mwstrb[k] = cur[k].wstrb;
          mvalid[k] = 1'b1;
        end
      end
    end
  end

  // Subordinate model: ready unless stalled, read data sub_lat cycles after accept
  initial begin : sub
    int            pend;
    logic [AW-1:0] paddr;
    logic [AW-1:0] a;
    bit            acc, rd;
    pend = 0; paddr = '0;
    s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    forever begin
      @(negedge clk);
      acc = s_valid & s_ready & cke;
      rd  = (s_wstrb == 4'h0);
      a   = s_addr;
      @(posedge clk);
      #1;
      s_rvalid = 1'b0;
      s_rdata  = '0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          s_rvalid = 1'b1;
          s_rdata  = 32'hCAFE_0000 + ({11'd0, paddr} >> 4);
          rv_cnt++;
        end
      end
      if (acc && rd) begin
        pend  = sub_lat;
        paddr = a;
      end
      s_ready = !sub_stall;
    end
  end

  // Monitor: pop and compare on every accept and every manager rvalid
  initial begin : mon
    acc_t          e;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      if (arst_n && cke && s_valid && s_ready) begin
        if (exp_acc.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_accept: got addr 0x%0h, expected no accept", s_addr);
        end else begin
          e = exp_acc.pop_front();
          chk("acc_ready_granted", mready[e.mgr], 1);
          chk("acc_ready_other", mready[!e.mgr], 0);
          chk("acc_addr", s_addr, e.t.addr);
          chk("acc_wdata", s_wdata, e.t.wdata);
          chk("acc_wstrb", s_wstrb, e.t.wstrb);
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (mrvalid[k]) begin
          if (exp_rd[k].size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_rvalid_m%0d: got rvalid 1, expected 0", k);
          end else begin
            d = exp_rd[k].pop_front();
            chk($sformatf("rdata_m%0d", k), mrdata[k], d);
            chk($sformatf("other_rvalid_m%0d", 1 - k), mrvalid[1 - k], 0);
            chk($sformatf("other_rdata_m%0d", 1 - k), mrdata[1 - k], 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    arst_n = 1'b0;
    cke    = 1'b1;
    do_reset();

    // M0 single read, data returned by the subordinate two cycles after accept
    issue(0, 21'h10, 32'h0, 4'h0);
    exp_a(0, 21'h10, 32'h0, 4'h0);
    exp_rd[0].push_back(32'hCAFE0001);
    wait_idle();
    chk("ptr_after_m0_read", dut.ptr_q, 1);

    // Simultaneous writes after reset: M0 first, then M1, pointer back to 0
    do_reset();
    issue(0, 21'h004, 32'h11111111, 4'hF);
    issue(1, 21'h008, 32'h22222222, 4'h3);
    exp_a(0, 21'h004, 32'h11111111, 4'hF);
    exp_a(1, 21'h008, 32'h22222222, 4'h3);
    wait_idle();
    chk("ptr_after_two_writes", dut.ptr_q, 0);

    // Four continuous reads from each manager: grants alternate
    for (int i = 0; i < 4; i++) begin
      issue(0, a0_tab[i], 32'h0, 4'h0);
      issue(1, a1_tab[i], 32'h0, 4'h0);
      exp_a(0, a0_tab[i], 32'h0, 4'h0);
      exp_a(1, a1_tab[i], 32'h0, 4'h0);
      exp_rd[0].push_back(r0_tab[i]);
      exp_rd[1].push_back(r1_tab[i]);
    end
    wait_idle();

    // Subordinate stalls five cycles during an M1 write
    sub_stall = 1'b1;
    @(posedge clk); #2;
    issue(1, 21'h1F0, 32'hA5A5A5A5, 4'hF);
    exp_a(1, 21'h1F0, 32'hA5A5A5A5, 4'hF);
    wait_state(ST_GRANT, "stall_grant");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_m1_ready", mready[1], 0);
      chk("stall_m0_ready", mready[0], 0);
      chk("stall_s_valid", s_valid, 1);
      chk("stall_s_addr", s_addr, 21'h1F0);
      chk("stall_s_wdata", s_wdata, 32'hA5A5A5A5);
      chk("stall_s_wstrb", s_wstrb, 4'hF);
    end
    sub_stall = 1'b0;
    wait_idle();

    // Reset in WAIT_R followed by a late rvalid
    issue(0, 21'h060, 32'h00000033, 4'h1);
    exp_a(0, 21'h060, 32'h00000033, 4'h1);
    wait_idle();
    chk("ptr_before_abandon", dut.ptr_q, 1);
    sub_lat = 6;
    issue(1, 21'h070, 32'h0, 4'h0);
    exp_a(1, 21'h070, 32'h0, 4'h0);
    wait_state(ST_WAIT_R, "abandon_wait_r");
    rv_cnt = 0;
    arst_n = 1'b0;
    #1;
    chk_quiet("midreset");
    @(negedge clk);
    arst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("late_rvalid_issued", rv_cnt, 1);
    chk("late_state", dut.state_q, 0);
    chk("late_ptr", dut.ptr_q, 0);
    sub_lat = 2;
    wait_idle();

    // Clock enable low for three cycles while in GRANT
    sub_stall = 1'b1;
    @(posedge clk); #2;
    issue(0, 21'h080, 32'h44444444, 4'hF);
    exp_a(0, 21'h080, 32'h44444444, 4'hF);
    wait_state(ST_GRANT, "cke_grant");
    @(posedge clk); #2;
    cke = 1'b0;
    sub_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cke_state", dut.state_q, 1);
      chk("cke_grant", dut.grant_q, 0);
      chk("cke_ptr", dut.ptr_q, 0);
    end
    chk("cke_ready_visible", mready[0], 1);
    @(posedge clk); #2;
    cke = 1'b1;
    wait_idle();
    chk("cke_ptr_after", dut.ptr_q, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
